// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the registered 1-to-2 demux
//   DEF_DATA_W / DEF_CNT_W : default data and counter widths
//   slot_state_t           : output slot occupancy (EMPTY / FULL)
//   OUT0 / OUT1            : select_b values that steer to output 0 / output 1
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam logic OUT0 = 1'b0;
    localparam logic OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry registered output slot with valid FSM
// Optional feature macro: DEMUX_COUNT_EN (saturating accepted-beat counter)
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : write in_data into the slot this cycle
//   in_data         : beat to store on load
//   out_ready       : consumer takes the held beat when out_valid & out_ready
//   can_accept      : slot is empty or is draining this cycle
//   out_valid       : slot holds a beat
//   out_data        : held beat (keeps last value after drain)
//   out_count       : loads seen, saturating (DEMUX_COUNT_EN only)
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              can_accept,
`ifdef DEMUX_COUNT_EN
    output logic [CNT_W-1:0]  out_count,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_t       state_q;
    logic [DATA_W-1:0] data_q;

    // A full slot whose consumer is taking the beat frees up in the same
    // cycle, so a new beat can land with no bubble.
    assign can_accept = (state_q == EMPTY) || out_ready;
    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_q <= FULL;
                        data_q  <= in_data;
                    end
                end
                FULL: begin
                    if (load) begin
                        // load implies out_ready here: drain and refill together
                        data_q <= in_data;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: rtl/demux_32_bit_1_2_reg.sv
// rtl/demux_32_bit_1_2_reg.sv - registered 32-bit 1-to-2 valid/ready demultiplexer
// Optional feature macro: DEMUX_COUNT_EN (out0_count / out1_count ports)
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  : input stream
//   select_b                   : 0 -> output 0, 1 -> output 1, sampled with the beat
//   outK_data/valid/ready      : registered output streams K = 0, 1
//   outK_count                 : saturating accepted-beat counters (DEMUX_COUNT_EN)
module demux_32_bit_1_2_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              select_b,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
`ifdef DEMUX_COUNT_EN
    output logic [CNT_W-1:0]  out0_count,
    output logic [CNT_W-1:0]  out1_count,
`endif
    input  logic              out1_ready
);

    logic accept0;
    logic accept1;
    logic load0;
    logic load1;

    // in_ready depends only on the targeted slot, never on in_valid.
    assign in_ready = (select_b == OUT1) ? accept1 : accept0;
    assign load0    = in_valid && in_ready && (select_b == OUT0);
    assign load1    = in_valid && in_ready && (select_b == OUT1);

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0),
        .in_data    (in_data),
        .out_ready  (out0_ready),
        .can_accept (accept0),
`ifdef DEMUX_COUNT_EN
        .out_count  (out0_count),
`endif
        .out_valid  (out0_valid),
        .out_data   (out0_data)
    );

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .in_data    (in_data),
        .out_ready  (out1_ready),
        .can_accept (accept1),
`ifdef DEMUX_COUNT_EN
        .out_count  (out1_count),
`endif
        .out_valid  (out1_valid),
        .out_data   (out1_data)
    );

endmodule

// File: tb/tb_demux_32_bit_1_2_reg.sv
// tb/tb_demux_32_bit_1_2_reg.sv - directed self-checking bench for demux_32_bit_1_2_reg
module tb_demux_32_bit_1_2_reg;

    localparam int TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        select_b;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX_COUNT_EN
    logic [TB_CNT_W-1:0] out0_count;
    logic [TB_CNT_W-1:0] out1_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    demux_32_bit_1_2_reg #(
        .DATA_W (32),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select_b   (select_b),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX_COUNT_EN
        .out0_count (out0_count),
        .out1_count (out1_count),
`endif
        .out1_ready (out1_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic sel, input logic [31:0] d);
        in_valid = 1'b1;
        select_b = sel;
        in_data  = d;
    endtask

    initial begin
        rst_n      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        select_b   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // reset asserted mid-cycle takes effect immediately
        #3 rst_n = 1'b0;
        #1;
        check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out0_data", out0_data, 32'd0);
        check("rst_out1_data", out1_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_COUNT_EN
        check("rst_out0_count", 32'(out0_count), 32'd0);
        check("rst_out1_count", 32'(out1_count), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        // steering
        @(negedge clk);
        send(1'b0, 32'hDEADBEEF);
        #1 check("steer_in_ready0", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("steer_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("steer_out0_data", out0_data, 32'hDEADBEEF);
        check("steer_out1_idle", {31'd0, out1_valid}, 32'd0);
        send(1'b1, 32'h12345678);
        @(negedge clk);
        check("steer_out1_valid", {31'd0, out1_valid}, 32'd1);
        check("steer_out1_data", out1_data, 32'h12345678);
        check("steer_out0_drained", {31'd0, out0_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("steer_out1_drained", {31'd0, out1_valid}, 32'd0);

        // stall isolation
        out0_ready = 1'b0;
        send(1'b0, 32'hAAAA0001);
        @(negedge clk);
        check("stall_fill_valid", {31'd0, out0_valid}, 32'd1);
        send(1'b0, 32'h5);
        #1 check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("stall_out0_hold", out0_data, 32'hAAAA0001);
        check("stall_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("stall_out1_idle", {31'd0, out1_valid}, 32'd0);
        select_b = 1'b1;
        #1 check("stall_switch_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("stall_out1_valid", {31'd0, out1_valid}, 32'd1);
        check("stall_out1_data", out1_data, 32'h5);
        check("stall_out0_still", out0_data, 32'hAAAA0001);
        in_valid = 1'b0;

        // drain and refill on the full, stalled slot 0
        @(negedge clk);
        out0_ready = 1'b1;
        send(1'b0, 32'h77);
        #1 check("refill_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("refill_valid", {31'd0, out0_valid}, 32'd1);
        check("refill_data", out0_data, 32'h77);
        in_valid = 1'b0;
        @(negedge clk);
        check("refill_drained", {31'd0, out0_valid}, 32'd0);
        check("refill_data_kept", out0_data, 32'h77);

        // back-to-back beats to out1, one per cycle
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 32'(i));
            @(negedge clk);
            check($sformatf("b2b_valid_%0d", i), {31'd0, out1_valid}, 32'd1);
            check($sformatf("b2b_data_%0d", i), out1_data, 32'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_done", {31'd0, out1_valid}, 32'd0);

        // reset in the middle of a stalled transfer discards the beat
        out1_ready = 1'b0;
        send(1'b1, 32'h99);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_full", {31'd0, out1_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out1_valid}, 32'd0);
        check("midrst_data", out1_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        check("midrst_no_replay", {31'd0, out1_valid}, 32'd0);

`ifdef DEMUX_COUNT_EN
        // saturating counters
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 32'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("cnt_out0_sat", 32'(out0_count), 32'd15);
        check("cnt_out1_zero", 32'(out1_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_32_bit_1_2_reg.md
# demux_32_bit_1_2_reg

Registered 32-bit 1-to-2 demultiplexer: accepts one valid/ready input stream and steers each beat to one of two output channels chosen by `select_b`, through a one-entry register per output. It is the inverse of the 32-bit 2-to-1 datapath mux and is used where one producer (e.g. ALU/memory result bus) feeds two consumers that may stall independently.

## Interface
- `DATA_W`, 32, data width of every data port
- `CNT_W`, 16, width of per-output beat counters (used only with `DEMUX_COUNT_EN`)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_W  input beat
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  input beat accepted this cycle when `in_valid & in_ready`
- `select_b`  in  1  0 steers to output 0, 1 steers to output 1; sampled with the beat
- `out0_data`, `out1_data`  out  DATA_W  registered output beats
- `out0_valid`, `out1_valid`  out  1  output slot holds a beat
- `out0_ready`, `out1_ready`  in  1  consumer takes beat when `valid & ready`
- `out0_count`, `out1_count`  out  CNT_W  accepted-beat counters (present only with `DEMUX_COUNT_EN`)

## Operation
- Each output slot is a 2-state FSM: EMPTY (valid=0) / FULL (valid=1).
- Slot k "can accept" = EMPTY, or FULL and `outk_ready`=1 (pass-through drain and refill same cycle).
- `in_ready` = can-accept of slot selected by `select_b`; combinational from `select_b`, `outk_valid`, `outk_ready`. No path from `in_valid` to `in_ready`.
- Load into slot k when `in_valid & in_ready & (select_b==k)`: `outk_data` <= `in_data`, slot -> FULL.
- Slot k FULL with `outk_ready`=1 and no load -> EMPTY; data register keeps last value.
- Slot FULL with `outk_ready`=0: `outk_data` and `outk_valid` held stable until taken.
- Non-selected slot is never written; a stalled output never blocks beats steered to the other output.
- Beats to the same output leave in acceptance order; no ordering between outputs.
- `select_b` changing while `in_valid`=1 and `in_ready`=0 is legal; `in_ready` re-evaluates for the new target.

## Timing
- Reset (async assert, sync release on `clk`): `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=0, counters 0; `in_ready` then reflects empty slots (=1).
- Reset mid-transfer discards both slot contents; no beat is replayed.
- Latency: beat accepted at edge N is visible on `outk_valid/outk_data` after edge N, consumable at edge N+1.
- Throughput: 1 beat/cycle per output when its consumer keeps `outk_ready`=1; zero bubble on drain-and-refill.
- Simultaneous drain and load on the same slot: slot stays FULL with new data.

## Configuration
- `DEMUX_COUNT_EN` defined: `out0_count`/`out1_count` ports exist; each increments by 1 on every load into its slot, saturating at 2^CNT_W-1 (no wrap); reset to 0.
- Not defined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared package `demux_pkg`: `DATA_W`/`CNT_W` defaults, `slot_state_t` enum {EMPTY, FULL}, output-index constants `OUT0`=0, `OUT1`=1.
- One sub-module `demux_out_slot` (one-entry register slot: load, drain, valid FSM, optional counter) instantiated twice; top holds only steering and `in_ready` select.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle -> both valids 0, data 0, `in_ready`=1 immediately; counters 0.
- Steering: send 0xDEADBEEF with `select_b`=0 then 0x12345678 with `select_b`=1, both readys 1 -> `out0_data`=0xDEADBEEF one cycle after accept, `out1_data`=0x12345678 next cycle; other valid stays 0.
- Stall isolation: hold `out0_ready`=0 with slot 0 FULL (0xAAAA0001); send 0x5 to select 0 -> `in_ready`=0, `out0_data` stable; switch `select_b`=1 -> 0x5 accepted to out1 same cycle.
- Back-to-back: 8 beats 1..8 to out1 with `out1_ready`=1 every cycle -> `out1_valid` high 8 consecutive cycles, data 1..8 in order, no bubble.
- Drain+refill: slot 0 FULL, `out0_ready`=1 and new beat 0x77 to select 0 same cycle -> slot stays FULL, `out0_data`=0x77.
- With `DEMUX_COUNT_EN`, `CNT_W`=4: 20 beats to out0 -> `out0_count`=15 (saturated), `out1_count`=0.
